// File: rtl/unpool_index_buffer_pkg.sv
// unpool_index_buffer_pkg: shared width helpers and the per-lane stored entry type.
package unpool_index_buffer_pkg;
    localparam int DEF_POOL_H = 2;
    localparam int DEF_POOL_W = 2;

    function automatic int group_width(input int h, input int w);
        return h * w;
    endfunction

    function automatic int pindex_width(input int h, input int w);
        return (h * w > 1) ? $clog2(h * w) : 1;
    endfunction

    // Entry layout for the default 2x2 window; the top derives its own for other geometries.
    typedef struct packed {
        logic [pindex_width(DEF_POOL_H, DEF_POOL_W)-1:0] pindex;
        logic                                            pbit;
    } unpool_entry_t;
endpackage

// File: rtl/unpool_index_buffer_if.sv
// unpool_index_buffer_if: writer (encoder) and reader (decoder) valid/ready channels.
interface unpool_index_buffer_if
    import unpool_index_buffer_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int POOL_H = 2,
    parameter int POOL_W = 2
);
    localparam int PW = pindex_width(POOL_H, POOL_W);
    localparam int GW = group_width(POOL_H, POOL_W);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [LANES*PW-1:0]   wr_pindex;
    logic [LANES-1:0]      wr_bit;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [LANES*GW-1:0]   rd_data;

    modport master (
        output wr_valid, wr_pindex, wr_bit, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );
    modport slave (
        input  wr_valid, wr_pindex, wr_bit, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/unpool_index_buffer_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with flush and a sticky overflow flag.
module sync_fifo #(
    parameter int DATA_WIDTH = 24,
    parameter int DEPTH      = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CW-1:0]         count,
    output logic                  overflow
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  do_wr, do_rd;

    assign wr_ready = count != CW'(DEPTH);
    assign rd_valid = count != '0;
    assign do_wr    = wr_valid & wr_ready & ~flush;
    assign do_rd    = rd_valid & rd_ready & ~flush;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_valid & ~wr_ready) overflow <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_wr) wr_ptr <= wr_ptr + 1'b1;
                if (do_rd) rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(do_wr) - CW'(do_rd);
            end
        end
    end

    // Storage is deliberately not reset; rd_valid gates its contents.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/unpool_index_buffer.sv
// unpool_index_buffer: buffers max-pool winners and replays them as sparse unpooled groups.
module unpool_index_buffer
    import unpool_index_buffer_pkg::*;
#(
    parameter int LANES  = 8,
    parameter int POOL_H = 2,
    parameter int POOL_W = 2,
    parameter int DEPTH  = 64,
    localparam int PINDEX_WIDTH = pindex_width(POOL_H, POOL_W),
    localparam int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    unpool_index_buffer_if.slave  bus,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow
);
    localparam int GW = group_width(POOL_H, POOL_W);
    localparam int EW = PINDEX_WIDTH + 1;

    typedef struct packed {
        logic [PINDEX_WIDTH-1:0] pindex;
        logic                    pbit;
    } lane_entry_t;

    lane_entry_t [0:LANES-1] wr_entry, rd_entry;

    for (genvar l = 0; l < LANES; l++) begin : g_pack
        assign wr_entry[l].pindex = bus.wr_pindex[(LANES-1-l)*PINDEX_WIDTH +: PINDEX_WIDTH];
        assign wr_entry[l].pbit   = bus.wr_bit[LANES-1-l];
    end

    sync_fifo #(
        .DATA_WIDTH(LANES * EW),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_valid (bus.wr_valid),
        .wr_ready (bus.wr_ready),
        .wr_data  (wr_entry),
        .rd_valid (bus.rd_valid),
        .rd_ready (bus.rd_ready),
        .rd_data  (rd_entry),
        .count    (count),
        .overflow (overflow)
    );

    // Out-of-range pindex matches no position, so the group stays zero.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar p = 0; p < GW; p++) begin : g_pos
            assign bus.rd_data[(LANES-1-l)*GW + GW-1-p] =
                rd_entry[l].pbit && (rd_entry[l].pindex == PINDEX_WIDTH'(p));
        end
    end
endmodule
